// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit packet sequencer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP,
    ST_JIDLE
  } tx_state_t;

  localparam logic [7:0]  SYNC_PATTERN    = 8'h80;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;

  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[0] ^ b;
    return fb ? ((crc >> 1) ^ CRC16_POLY_REFL) : (crc >> 1);
  endfunction

endpackage

// File: rtl/usb_crc16_serial.sv
// Bit-serial reflected CRC16 (USB data CRC); one payload bit per enabled cycle.
module usb_crc16_serial
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      crc_out <= CRC16_INIT;
    else if (clear)  crc_out <= CRC16_INIT;
    else if (bit_en) crc_out <= crc16_step(crc_out, bit_in);
  end

endmodule

// File: rtl/usb_tx_pkt_ctrl.sv
// USB FS transmit packet sequencer: SYNC, PID, payload, CRC16, EOP with bit stuffing.
// Optional packet/underrun statistics counters are built when USB_TX_STATS_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for tx_start, bit timer stopped
// ST_SYNC  | 8 SYNC bits
// ST_PID   | PID byte, LSB first
// ST_DATA  | payload bytes fetched from the FIFO, LSB first
// ST_CRC   | inverted CRC16, LSB first
// ST_EOP   | two SE0 bit periods
// ST_JIDLE | one bit period forcing J before returning to idle
module usb_tx_pkt_ctrl
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        tx_start,
  input  logic [3:0]  tx_pid,
  input  logic        tx_has_data,
  input  logic [7:0]  tx_byte,
  input  logic        tx_byte_valid,
  input  logic        tx_last,
  output logic        tx_byte_ready,
  output logic        serial_out,
  output logic        encoder_enable,
  output logic        eop_enable,
  output logic        clock_timer,
  output logic        force_j,
  output logic        tx_busy,
  output logic        tx_done,
`ifdef USB_TX_STATS_EN
  output logic [15:0] pkt_count,
  output logic [7:0]  underrun_count,
`endif
  output logic        tx_underrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_next;
  logic [CW-1:0] cnt;
  logic [3:0]    idx, idx_next;
  logic          stuff, stuff_next;
  logic [2:0]    ones;
  logic [7:0]    shreg;
  logic          last_r, has_data_r, done_r;
  logic [3:0]    pid_r;
  logic [15:0]   crc;

  logic strobe, period_end, start, byte_start, fetch, underrun, line_active, bit_now;
  logic [7:0] pid_byte;

  assign pid_byte    = {~pid_r, pid_r};
  assign strobe      = (state != ST_IDLE) && (cnt == '0);
  assign period_end  = (state != ST_IDLE) && (cnt == CNT_LAST);
  assign start       = (state == ST_IDLE) && tx_start;
  assign byte_start  = (state == ST_DATA) && (idx == 4'd0) && !stuff;
  assign fetch       = strobe && byte_start && tx_byte_valid;
  assign underrun    = strobe && byte_start && !tx_byte_valid;
  // A pending stuffed bit owns the line even after the state has moved on to EOP.
  assign line_active = stuff || (state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC});

  // Bit driven for the current period; the first bit of a byte bypasses the latch.
  always_comb begin
    bit_now = 1'b0;
    if (!stuff) begin
      case (state)
        ST_SYNC: bit_now = SYNC_PATTERN[idx[2:0]];
        ST_PID:  bit_now = pid_byte[idx[2:0]];
        ST_DATA: bit_now = fetch ? tx_byte[0] : shreg[idx[2:0]];
        ST_CRC:  bit_now = ~crc[idx];
        default: bit_now = 1'b0;
      endcase
    end
  end

  usb_crc16_serial u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (start),
    .bit_en (period_end && (state == ST_DATA) && !stuff),
    .bit_in (bit_now),
    .crc_out(crc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      stuff      <= 1'b0;
      ones       <= '0;
      shreg      <= '0;
      last_r     <= 1'b0;
      has_data_r <= 1'b0;
      pid_r      <= '0;
      done_r     <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      stuff  <= stuff_next;
      done_r <= period_end && (state == ST_JIDLE);
      if ((state == ST_IDLE) || period_end) cnt <= '0;
      else                                 cnt <= cnt + 1'b1;
      if (start) begin
        pid_r      <= tx_pid;
        has_data_r <= tx_has_data;
        last_r     <= 1'b0;
        ones       <= '0;
      end
      if (fetch) begin
        shreg  <= tx_byte;
        last_r <= tx_last;
      end
      if (period_end) begin
        if (line_active && bit_now) ones <= ones + 3'd1;
        else                        ones <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    stuff_next = stuff;
    if (start) begin
      state_next = ST_SYNC;
      idx_next   = '0;
      stuff_next = 1'b0;
    end else if (underrun) begin
      state_next = ST_EOP;
      idx_next   = '0;
    end else if (period_end) begin
      if (stuff) begin
        stuff_next = 1'b0;
      end else begin
        stuff_next = line_active && bit_now && (ones == STUFF_LIMIT - 3'd1);
        idx_next   = idx + 4'd1;
        case (state)
          ST_SYNC: if (idx == 4'd7) begin
            state_next = ST_PID;
            idx_next   = '0;
          end
          ST_PID: if (idx == 4'd7) begin
            idx_next = '0;
            if (!has_data_r)                    state_next = ST_EOP;
            else if (!tx_byte_valid && tx_last) state_next = ST_CRC;
            else                                state_next = ST_DATA;
          end
          ST_DATA: if (idx == 4'd7) begin
            idx_next   = '0;
            state_next = last_r ? ST_CRC : ST_DATA;
          end
          ST_CRC: if (idx == 4'd15) begin
            idx_next   = '0;
            state_next = ST_EOP;
          end
          ST_EOP: if (idx == 4'd1) begin
            idx_next   = '0;
            state_next = ST_JIDLE;
          end
          default: begin
            idx_next   = '0;
            state_next = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    serial_out     = bit_now && !underrun;
    encoder_enable = line_active && !underrun;
    eop_enable     = ((state == ST_EOP) && !stuff) || underrun;
    force_j        = (state == ST_JIDLE);
    clock_timer    = strobe;
    tx_busy        = (state != ST_IDLE);
    tx_done        = done_r;
    tx_byte_ready  = fetch;
    tx_underrun    = underrun;
  end

`ifdef USB_TX_STATS_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pkt_count      <= '0;
      underrun_count <= '0;
    end else begin
      if (done_r) pkt_count <= pkt_count + 16'd1;
      if (underrun && (underrun_count != 8'hFF)) underrun_count <= underrun_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Directed bench for usb_tx_pkt_ctrl: packet table plus reset/restart corner sequences.
module tb_usb_tx_pkt_ctrl;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid = '0;
  logic       tx_has_data = 1'b0;
  logic [7:0] tx_byte = '0;
  logic       tx_byte_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic tx_byte_ready, serial_out, encoder_enable, eop_enable, clock_timer;
  logic force_j, tx_busy, tx_done, tx_underrun;

  usb_tx_pkt_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_pid(tx_pid),
    .tx_has_data(tx_has_data), .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid),
    .tx_last(tx_last), .tx_byte_ready(tx_byte_ready), .serial_out(serial_out),
    .encoder_enable(encoder_enable), .eop_enable(eop_enable), .clock_timer(clock_timer),
    .force_j(force_j), .tx_busy(tx_busy), .tx_done(tx_done), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [3:0] pid;
    logic       has_data;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       starve;
    logic       restart;
    string      line;
    int         exp_strobes;
    int         exp_pops;
    int         exp_under;
  } row_t;

  row_t rows[6];

  logic [7:0] fifo[2];
  int rd, nfifo;
  logic starve_r;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive_fifo();
    tx_byte_valid = (rd < nfifo);
    tx_byte       = (rd < nfifo) ? fifo[rd] : 8'h00;
    tx_last       = (rd < nfifo) ? ((rd == nfifo - 1) && !starve_r) : ((nfifo == 0) && !starve_r);
  endtask

  function automatic int outs();
    return int'({serial_out, encoder_enable, eop_enable, clock_timer, force_j,
                 tx_busy, tx_done, tx_underrun, tx_byte_ready});
  endfunction

  task automatic run_row(input row_t r);
    int strobes, pops, unders, first_cyc, done_cyc, bit_err, hold_err, busy_err, idle_err, n, len;
    int bad_k;
    logic [3:0] got, exp, last_got, bad_got, bad_exp;
    bit done, pend;
    strobes = 0; pops = 0; unders = 0; done_cyc = 0; bit_err = 0; hold_err = 0;
    busy_err = 0; idle_err = 0; n = 0; done = 0; pend = 0; last_got = '0;
    bad_k = 0; bad_got = '0; bad_exp = '0;
    len = r.line.len();
    fifo[0] = r.b0; fifo[1] = r.b1; nfifo = r.nbytes; starve_r = r.starve; rd = 0;
    drive_fifo();
    @(posedge clk); #1;
    tx_start = 1'b1; tx_pid = r.pid; tx_has_data = r.has_data;
    @(posedge clk); #1;
    tx_start = 1'b0; tx_pid = 4'h0; tx_has_data = 1'b0;
    @(negedge clk);
    check({r.name, " start_latency"}, int'({clock_timer, tx_busy}), 3);
    first_cyc = cyc;
    while (!done && n < 400) begin
      if (r.restart && n == 10) begin tx_start = 1'b1; tx_pid = 4'hB; tx_has_data = 1'b1; end
      if (r.restart && n == 30) begin tx_start = 1'b0; tx_pid = 4'h0; tx_has_data = 1'b0; end
      if (tx_done) begin
        done = 1;
        done_cyc = cyc;
        if (tx_busy) busy_err++;
      end else begin
        if (!tx_busy) busy_err++;
        got = {serial_out, encoder_enable, eop_enable, force_j};
        if (clock_timer) begin
          if (strobes < len)           exp = {(r.line[strobes] == "1"), 3'b100};
          else if (strobes < len + 2)  exp = 4'b0010;
          else                         exp = 4'b0001;
          if (strobes > len + 2) exp = 4'b1111;
          if (got !== exp) begin
            if (bit_err == 0) begin bad_k = strobes; bad_got = got; bad_exp = exp; end
            bit_err++;
          end
          strobes++;
          last_got = got;
        end else if (strobes > 0 && got !== last_got) begin
          hold_err++;
        end
        if (tx_byte_ready) begin pops++; pend = 1; end
        if (tx_underrun) unders++;
      end
      if (!done) begin
        @(posedge clk); #1;
        if (pend) begin rd++; pend = 0; drive_fifo(); end
        @(negedge clk);
        n++;
      end
    end
    tx_start = 1'b0;
    check({r.name, " done_seen"}, int'(done), 1);
    checks++;
    if (bit_err != 0) begin
      errors++;
      $display("FAIL %s stream strobe %0d got %b required %b (%0d bad strobes)",
               r.name, bad_k, bad_got, bad_exp, bit_err);
    end
    check({r.name, " strobe_count"}, strobes, r.exp_strobes);
    check({r.name, " done_latency"}, done_cyc - first_cyc, r.exp_strobes * CPB);
    check({r.name, " pops"}, pops, r.exp_pops);
    check({r.name, " underruns"}, unders, r.exp_under);
    check({r.name, " busy_errors"}, busy_err, 0);
    check({r.name, " hold_errors"}, hold_err, 0);
    repeat (4) begin
      @(negedge clk);
      if (clock_timer || tx_busy || tx_done) idle_err++;
    end
    check({r.name, " idle_quiet"}, idle_err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    rows[0] = '{"ack", 4'h2, 1'b0, 0, 8'h00, 8'h00, 1'b0, 1'b0,
                "0000000101001011", 19, 0, 0};
    rows[1] = '{"zlp_data0", 4'h3, 1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b0,
                {"00000001", "11000011", "0000000000000000"}, 35, 0, 0};
    rows[2] = '{"stuff_ffff", 4'h3, 1'b1, 2, 8'hFF, 8'hFF, 1'b0, 1'b0,
                {"00000001", "11000011", "11110", "1111110", "1111110", "1111110", "1111110", "1111"},
                56, 2, 0};
    rows[3] = '{"underrun", 4'hB, 1'b1, 1, 8'h5A, 8'h00, 1'b1, 1'b0,
                {"00000001", "11010010", "01011010"}, 27, 1, 1};
    rows[4] = '{"data1_00", 4'hB, 1'b1, 1, 8'h00, 8'h00, 1'b0, 1'b0,
                {"00000001", "11010010", "00000000", "00000010", "111111", "0", "01"}, 44, 1, 0};
    rows[5] = '{"ack_restart", 4'h2, 1'b0, 0, 8'h00, 8'h00, 1'b0, 1'b1,
                "0000000101001011", 19, 0, 0};

    rd = 0; nfifo = 0; starve_r = 1'b0;
    drive_fifo();
    @(negedge clk);
    check("reset_outputs", outs(), 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", outs(), 0);

    for (int i = 0; i < 6; i++) run_row(rows[i]);

    // Reset in the middle of a data byte.
    fifo[0] = 8'hFF; fifo[1] = 8'hFF; nfifo = 2; starve_r = 1'b0; rd = 0;
    drive_fifo();
    @(posedge clk); #1;
    tx_start = 1'b1; tx_pid = 4'h3; tx_has_data = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    seen = 0; n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      if (tx_byte_ready) seen = 1;
      n++;
    end
    check("rst_mid_fetch_seen", int'(seen), 1);
    repeat (2) @(posedge clk);
    #2;
    check("rst_mid_active", int'({tx_busy, encoder_enable, serial_out}), 7);
    n_rst = 1'b0;
    #1;
    check("rst_mid_outputs", outs(), 0);
    @(negedge clk);
    check("rst_mid_held", outs(), 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    run_row(rows[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
